// File: rtl/branch_predictor_table_pkg.sv
// rtl/branch_predictor_table_pkg.sv - shared predictor constants and index hash
package bp_pkg;

    localparam int MAX_IDX_W = 8;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Weakly not-taken: just below the taken threshold.
    function automatic int cnt_init(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    // PC slice XOR zero-extended history; bits above the slice alias freely.
    function automatic logic [MAX_IDX_W-1:0] bp_index(input logic [31:0] pc, input logic [31:0] hist,
                                                      input int idx_lsb, input int idx_w);
        logic [31:0] mask;
        logic [31:0] raw;
        mask = (32'd1 << idx_w) - 32'd1;
        raw  = (pc >> idx_lsb) ^ hist;
        return MAX_IDX_W'(raw & mask);
    endfunction

endpackage

// File: rtl/branch_predictor_table_if.sv
// rtl/branch_predictor_table_if.sv - lookup, prediction and resolution signals
interface branch_predictor_table_if #(
    parameter int PC_W   = 7,
    parameter int HIST_W = 0
);
    localparam int HW = (HIST_W > 0) ? HIST_W : 1;

    logic            en;
    logic [PC_W-1:0] lookup_pc;
    logic            pred_taken;
    logic            pred_valid;
    logic [HW-1:0]   pred_hist;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [HW-1:0]   upd_hist;
    logic            upd_taken;
    logic            upd_jump;

    modport master (
        output en, lookup_pc, upd_valid, upd_pc, upd_hist, upd_taken, upd_jump,
        input  pred_taken, pred_valid, pred_hist
    );

    modport slave (
        input  en, lookup_pc, upd_valid, upd_pc, upd_hist, upd_taken, upd_jump,
        output pred_taken, pred_valid, pred_hist
    );
endinterface

// File: rtl/branch_predictor_table_sat_counter.sv
// rtl/branch_predictor_table_sat_counter.sv - one saturating direction counter
module sat_counter #(
    parameter int              CNT_W = 2,
    parameter logic [CNT_W-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt
);
    logic [CNT_W-1:0] cnt_q;

    // Next value with clamping at both ends; exposed for the lookup bypass.
    always_comb begin
        cnt_nxt = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end
    end

    // Counter state; reset wins over any concurrent update.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= INIT;
        else     cnt_q <= cnt_nxt;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/branch_predictor_table.sv
// rtl/branch_predictor_table.sv - bimodal/gshare direction predictor table
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int PC_W    = 7,
    parameter int ENTRIES = 8,
    parameter int CNT_W   = 2,
    parameter int IDX_LSB = 2,
    parameter int HIST_W  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    branch_predictor_table_if.slave  bus
);
    localparam int               IDX_W = clog2(ENTRIES);
    localparam int               HW    = (HIST_W > 0) ? HIST_W : 1;
    localparam logic [CNT_W-1:0] INIT  = CNT_W'(cnt_init(CNT_W));

    logic [HW-1:0]          ghr_q;
    logic [HW-1:0]          lk_hist;
    logic [HW-1:0]          up_hist;
    logic [MAX_IDX_W-1:0]   lk_idx_full;
    logic [MAX_IDX_W-1:0]   up_idx_full;
    logic [IDX_W-1:0]       lk_idx;
    logic [IDX_W-1:0]       up_idx;
    logic                   upd_dir;
    logic [CNT_W-1:0]       cnt_val [ENTRIES];
    logic [CNT_W-1:0]       cnt_nxt [ENTRIES];
    logic [CNT_W-1:0]       lk_cnt;
    logic                   pred_taken_q;
    logic                   pred_valid_q;
    logic [HW-1:0]          pred_hist_q;

    // History only participates in the hash in gshare mode.
    always_comb begin
        lk_hist = (HIST_W > 0) ? ghr_q : '0;
        up_hist = (HIST_W > 0) ? bus.upd_hist : '0;
    end

    assign lk_idx_full = bp_index(32'(bus.lookup_pc), 32'(lk_hist), IDX_LSB, IDX_W);
    assign up_idx_full = bp_index(32'(bus.upd_pc), 32'(up_hist), IDX_LSB, IDX_W);
    assign lk_idx      = lk_idx_full[IDX_W-1:0];
    assign up_idx      = up_idx_full[IDX_W-1:0];
    assign upd_dir     = bus.upd_taken | bus.upd_jump;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
        logic hit;
        assign hit = bus.upd_valid && (up_idx == IDX_W'(g));
        sat_counter #(.CNT_W(CNT_W), .INIT(INIT)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (hit && upd_dir),
            .dec     (hit && !upd_dir),
            .cnt     (cnt_val[g]),
            .cnt_nxt (cnt_nxt[g])
        );
    end

    // Same-index update this cycle is forwarded so the prediction sees the written value.
    always_comb begin
        lk_cnt = cnt_val[lk_idx];
        if (bus.upd_valid && (up_idx == lk_idx)) lk_cnt = cnt_nxt[up_idx];
    end

    // Prediction pipeline register; taken and hist hold while fetch is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_taken_q <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_hist_q  <= '0;
        end else if (bus.en) begin
            pred_taken_q <= lk_cnt[CNT_W-1];
            pred_valid_q <= 1'b1;
            pred_hist_q  <= lk_hist;
        end else begin
            pred_valid_q <= 1'b0;
        end
    end

    // Non-speculative global history, shifted only by resolved branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else if (bus.upd_valid && (HIST_W > 0)) begin
            ghr_q <= HW'({ghr_q, upd_dir});
        end
    end

    assign bus.pred_taken = pred_taken_q;
    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_hist  = pred_hist_q;
endmodule

// File: tb/tb_branch_predictor_table.sv
// tb/tb_branch_predictor_table.sv - directed vector bench, bimodal and gshare instances
module tb_branch_predictor_table;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_table_if #(.PC_W(7), .HIST_W(0)) bus_b ();
    branch_predictor_table_if #(.PC_W(7), .HIST_W(2)) bus_g ();

    branch_predictor_table #(.PC_W(7), .ENTRIES(8), .CNT_W(2), .IDX_LSB(2), .HIST_W(0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );
    branch_predictor_table #(.PC_W(7), .ENTRIES(8), .CNT_W(2), .IDX_LSB(2), .HIST_W(2)) dut_g (
        .clk (clk), .rst (rst), .bus (bus_g)
    );

    typedef struct {
        logic       en;
        logic [6:0] lk_pc;
        logic       upd_v;
        logic [6:0] upd_pc;
        logic [1:0] upd_hist;
        logic       upd_t;
        logic       upd_j;
        logic       exp_v;
        logic       exp_t;
        logic [1:0] exp_hist;
        int         chk_idx;
        logic [1:0] exp_cnt;
        logic [1:0] exp_ghr;
    } vec_t;

    vec_t vb[$];
    vec_t vg[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic en, logic [6:0] lk_pc, logic upd_v, logic [6:0] upd_pc,
                                logic [1:0] upd_hist, logic upd_t, logic upd_j, logic exp_v,
                                logic exp_t, logic [1:0] exp_hist, int chk_idx, logic [1:0] exp_cnt,
                                logic [1:0] exp_ghr);
        vec_t v;
        v.en = en; v.lk_pc = lk_pc; v.upd_v = upd_v; v.upd_pc = upd_pc; v.upd_hist = upd_hist;
        v.upd_t = upd_t; v.upd_j = upd_j; v.exp_v = exp_v; v.exp_t = exp_t; v.exp_hist = exp_hist;
        v.chk_idx = chk_idx; v.exp_cnt = exp_cnt; v.exp_ghr = exp_ghr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_b(input vec_t v);
        bus_b.en = v.en; bus_b.lookup_pc = v.lk_pc; bus_b.upd_valid = v.upd_v;
        bus_b.upd_pc = v.upd_pc; bus_b.upd_hist = v.upd_hist[0]; bus_b.upd_taken = v.upd_t;
        bus_b.upd_jump = v.upd_j;
    endtask

    task automatic drive_g(input vec_t v);
        bus_g.en = v.en; bus_g.lookup_pc = v.lk_pc; bus_g.upd_valid = v.upd_v;
        bus_g.upd_pc = v.upd_pc; bus_g.upd_hist = v.upd_hist; bus_g.upd_taken = v.upd_t;
        bus_g.upd_jump = v.upd_j;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        vec_t pre;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        drive_b(idle);
        drive_g(idle);
        tick();
        tick();
        rst = 1'b0;

        // Dirty some state, then reset with update and lookup active.
        pre = mk(0, 0, 1, 7'h08, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive_b(pre); drive_g(pre);
        tick();
        pre = mk(1, 7'h08, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_b(pre); drive_g(pre);
        tick();
        chk("pre_rst taken", 32'(bus_b.pred_taken), 1);
        chk("pre_rst valid", 32'(bus_b.pred_valid), 1);
        rst = 1'b1;
        pre = mk(1, 7'h08, 1, 7'h08, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive_b(pre); drive_g(pre);
        tick();
        rst = 1'b0;
        drive_b(idle); drive_g(idle);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rst_b cnt%0d", i), 32'(dut_b.cnt_val[i]), 1);
            chk($sformatf("rst_g cnt%0d", i), 32'(dut_g.cnt_val[i]), 1);
        end
        chk("rst_b taken", 32'(bus_b.pred_taken), 0);
        chk("rst_b valid", 32'(bus_b.pred_valid), 0);
        chk("rst_b hist",  32'(bus_b.pred_hist), 0);
        chk("rst_g taken", 32'(bus_g.pred_taken), 0);
        chk("rst_g valid", 32'(bus_g.pred_valid), 0);
        chk("rst_g hist",  32'(bus_g.pred_hist), 0);
        chk("rst_g ghr",   32'(dut_g.ghr_q), 0);

        // Bimodal: en, lk_pc, upd_v, upd_pc, upd_hist, upd_t, upd_j, exp_v, exp_t, exp_hist, idx, cnt, ghr
        vb.push_back(mk(0, 0,     1, 7'h08, 0, 1, 0, 0, 0, 0, 2, 2, 0));
        vb.push_back(mk(0, 0,     1, 7'h08, 0, 1, 0, 0, 0, 0, 2, 3, 0));
        vb.push_back(mk(0, 0,     1, 7'h08, 0, 1, 0, 0, 0, 0, 2, 3, 0));
        vb.push_back(mk(0, 0,     1, 7'h08, 0, 1, 0, 0, 0, 0, 2, 3, 0));
        vb.push_back(mk(1, 7'h08, 0, 0,     0, 0, 0, 1, 1, 0, 2, 3, 0));
        vb.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 1, 0, 2, 3, 0));
        vb.push_back(mk(0, 0,     1, 7'h08, 0, 0, 0, 0, 1, 0, 2, 2, 0));
        vb.push_back(mk(0, 0,     1, 7'h08, 0, 0, 0, 0, 1, 0, 2, 1, 0));
        vb.push_back(mk(0, 0,     1, 7'h08, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        vb.push_back(mk(0, 0,     1, 7'h08, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        vb.push_back(mk(0, 0,     1, 7'h08, 0, 0, 0, 0, 1, 0, 2, 0, 0));
        vb.push_back(mk(1, 7'h08, 0, 0,     0, 0, 0, 1, 0, 0, 2, 0, 0));
        vb.push_back(mk(0, 0,     1, 7'h28, 0, 1, 0, 0, 0, 0, 2, 1, 0));
        vb.push_back(mk(1, 7'h0C, 1, 7'h0C, 0, 1, 0, 1, 1, 0, 3, 2, 0));
        vb.push_back(mk(1, 7'h0C, 1, 7'h08, 0, 0, 0, 1, 1, 0, 2, 0, 0));
        vb.push_back(mk(1, 7'h0C, 1, 7'h0C, 0, 0, 0, 1, 0, 0, 3, 1, 0));
        vb.push_back(mk(0, 0,     1, 7'h10, 0, 0, 1, 0, 0, 0, 4, 2, 0));
        vb.push_back(mk(1, 7'h10, 0, 0,     0, 0, 0, 1, 1, 0, 4, 2, 0));
        vb.push_back(mk(1, 7'h00, 0, 0,     0, 0, 0, 1, 0, 0, 0, 1, 0));
        vb.push_back(mk(1, 7'h50, 0, 0,     0, 0, 0, 1, 1, 0, 4, 2, 0));

        // Gshare, HIST_W=2, idx = pc[4:2] ^ hist
        vg.push_back(mk(0, 0,     1, 7'h10, 0, 1, 0, 0, 0, 0, 4, 2, 1));
        vg.push_back(mk(0, 0,     1, 7'h10, 0, 1, 0, 0, 0, 0, 4, 3, 3));
        vg.push_back(mk(1, 7'h00, 0, 0,     0, 0, 0, 1, 0, 3, 3, 1, 3));
        vg.push_back(mk(1, 7'h00, 1, 7'h00, 3, 1, 0, 1, 1, 3, 3, 2, 3));
        vg.push_back(mk(0, 0,     0, 0,     0, 0, 0, 0, 1, 3, 0, 1, 3));
        vg.push_back(mk(1, 7'h00, 1, 7'h04, 0, 0, 0, 1, 1, 3, 1, 0, 2));
        vg.push_back(mk(0, 0,     1, 7'h04, 0, 0, 1, 0, 1, 3, 1, 1, 1));
        vg.push_back(mk(1, 7'h00, 0, 0,     0, 0, 0, 1, 0, 1, 1, 1, 1));

        foreach (vb[i]) begin
            drive_b(vb[i]);
            tick();
            chk($sformatf("bim[%0d] valid", i), 32'(bus_b.pred_valid), 32'(vb[i].exp_v));
            chk($sformatf("bim[%0d] taken", i), 32'(bus_b.pred_taken), 32'(vb[i].exp_t));
            chk($sformatf("bim[%0d] hist", i), 32'(bus_b.pred_hist), 32'(vb[i].exp_hist));
            chk($sformatf("bim[%0d] cnt%0d", i, vb[i].chk_idx), 32'(dut_b.cnt_val[vb[i].chk_idx]), 32'(vb[i].exp_cnt));
        end
        drive_b(idle);

        foreach (vg[i]) begin
            drive_g(vg[i]);
            tick();
            chk($sformatf("gsh[%0d] valid", i), 32'(bus_g.pred_valid), 32'(vg[i].exp_v));
            chk($sformatf("gsh[%0d] taken", i), 32'(bus_g.pred_taken), 32'(vg[i].exp_t));
            chk($sformatf("gsh[%0d] hist", i), 32'(bus_g.pred_hist), 32'(vg[i].exp_hist));
            chk($sformatf("gsh[%0d] cnt%0d", i, vg[i].chk_idx), 32'(dut_g.cnt_val[vg[i].chk_idx]), 32'(vg[i].exp_cnt));
            chk($sformatf("gsh[%0d] ghr", i), 32'(dut_g.ghr_q), 32'(vg[i].exp_ghr));
        end
        drive_g(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
